shift_arbiter: RTL
==================

# shift_arbiter

Shares the single 8-bit shifter datapath between NREQ requesters (core ALU, I/O unit, ...) and sequences long shifts. Grants are round-robin. Shift amounts of 0–15 are decomposed into shifter passes of at most 7, with the result fed back each pass. Sits between the requesting units and one internal shifter instance; responses are single-cycle pulses with no backpressure.

## Interface
- NREQ, default 2: number of requesters, 2..4.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NREQ  per-requester request strobe; held until accepted.
- req_ready  out  NREQ  one-hot accept; request i is accepted in the cycle where req_valid[i] && req_ready[i].
- req_data  in  8*NREQ  operand; slice i is bits [8i+7:8i].
- req_amt  in  4*NREQ  shift amount 0..15; slice i is bits [4i+3:4i].
- req_lr  in  NREQ  direction; 1 = left, 0 = right. This matches the shifter's implemented behaviour.
- req_arith  in  NREQ  for right shifts only: 1 = arithmetic (sign fill), 0 = logical. Ignored for left shifts.
- resp_valid  out  NREQ  one-hot, single-cycle completion pulse to the owning requester.
- resp_data  out  8  result; valid only while any resp_valid bit is set, otherwise 0.
- busy  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, SHIFT, RESP.
- **IDLE**
  - req_ready is combinational: the one-hot grant g is the first requester with req_valid set, searched from ptr upward, wrapping modulo NREQ.
  - On the clock edge with a grant, latch operand into acc, latch amt into rem, latch lr, arith and g, then go to SHIFT.
  - Update ptr to (g+1) mod NREQ.
  - With no valid request, stay in IDLE and keep req_ready at 0.
- **SHIFT**
  - Drive the shifter with in = acc, by = step, lr and arith from the latched values, where step = (rem > 7) ? 7 : rem[2:0].
  - Each edge: acc <= shifter out, rem <= rem − step.
  - When rem − step == 0, go to RESP.
  - amt = 0 still spends exactly one SHIFT cycle with step 0, so the result equals the operand.
- **RESP**
  - resp_valid[g] = 1 and resp_data = acc for one cycle.
  - Return to IDLE unconditionally.
  - No request is granted in RESP.
- Decomposition yields the mathematically correct 8-bit result for every amount:
  - left or logical right by ≥8 gives 0x00;
  - arithmetic right by ≥8 gives 0x00 or 0xFF according to the sign.
- req_ready is 0 in SHIFT and RESP. Requests that are not granted stay pending and are never dropped.
- Input changes on requester ports after acceptance have no effect on the operation in flight.

## Timing
- Reset values: state = IDLE, ptr = 0, acc = 0, rem = 0, g = 0. Outputs req_ready, resp_valid, resp_data and busy are all 0.
- Number of SHIFT cycles: 1 for amt 0..7, 2 for amt 8..14, 3 for amt 15.
- Latency: the response pulse occurs SHIFT-count + 1 cycles after the accept edge, i.e. 2, 3 or 4 cycles.
- Throughput: one operation per SHIFT-count + 2 cycles, because IDLE is revisited for one cycle between operations.
- Simultaneous requests: the ptr-first requester wins; the loser is granted at the next IDLE.
- Reset asserted mid-operation:
  - the in-flight operation is discarded and no resp_valid is produced;
  - ptr returns to 0.
  - After release, pending req_valid is regranted from IDLE.
- Requests asserted while busy: they wait and cause no state change.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT, RESP);
  - the constants MAX_STEP = 7, DATA_W = 8, AMT_W = 4.
- One sub-module: `shifter`, instantiated once. The arbiter contains only the FSM, the round-robin pointer and the acc/rem registers.

## Test plan
- Single request from req 0, data 0x81, amt 3, lr 0, arith 1: resp_valid[0] arrives 2 cycles after accept with resp_data 0xF0; busy is high through both cycles.
- req 1, data 0x80, amt 15, lr 0, arith 1: 3 SHIFT cycles, resp_data 0xFF, pulse 4 cycles after accept. Same input with arith 0 gives 0x00.
- req 0, data 0x01, amt 9, lr 1: 2 SHIFT cycles, resp_data 0x00. Same with amt 0 and data 0x5A gives 0x5A after 2 cycles.
- Both requesters held valid continuously from reset: grants alternate 0, 1, 0, 1. Each resp_valid goes to the matching requester; no starvation over 20 operations.
- Reset pulsed during the second SHIFT cycle of an amt 10 operation: no resp_valid, all outputs 0. The held request is re-accepted from requester 0 first.
- Requester changes req_data during SHIFT: result reflects the latched operand only.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter and its shifter datapath.
// No logic; no latency; no backpressure.
package shift_arbiter_pkg;

    localparam int DATA_W   = 8;
    localparam int AMT_W    = 4;
    localparam int MAX_STEP = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Single-pass 8-bit barrel shifter, left / logical right / arithmetic right by 0..7.
// Purely combinational; no backpressure.
module shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [2:0]        by,
    input  logic              lr,
    input  logic              arith,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] shl;
    logic [DATA_W-1:0] shr;
    logic [DATA_W-1:0] sra;

    assign shl  = din << by;
    assign shr  = din >> by;
    assign sra  = $unsigned($signed(din) >>> by);
    assign dout = lr ? shl : (arith ? sra : shr);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter; long shifts run as passes of at most 7.
// Response 2..4 cycles after accept; req_ready low while busy, responses never stall.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W*NREQ-1:0] req_data,
    input  logic [AMT_W*NREQ-1:0]  req_amt,
    input  logic [NREQ-1:0]        req_lr,
    input  logic [NREQ-1:0]        req_arith,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   busy
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  g;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand;
    logic              found;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] shift_out;
    logic [AMT_W-1:0]  rem;
    logic [AMT_W-1:0]  rem_nxt;
    logic [AMT_W-1:0]  sel_amt;
    logic [2:0]        step;
    logic              lr;
    logic              arith;
    logic              sel_lr;
    logic              sel_arith;

    // Search from ptr upward, wrapping, for the first valid requester.
    always_comb begin
        grant_idx = ptr;
        found     = 1'b0;
        cand      = ptr;
        for (int i = 0; i < NREQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        sel_data  = req_data[DATA_W-1:0];
        sel_amt   = req_amt[AMT_W-1:0];
        sel_lr    = req_lr[0];
        sel_arith = req_arith[0];
        for (int j = 0; j < NREQ; j++) begin
            if (PTR_W'(j) == grant_idx) begin
                sel_data  = req_data[j*DATA_W +: DATA_W];
                sel_amt   = req_amt[j*AMT_W +: AMT_W];
                sel_lr    = req_lr[j];
                sel_arith = req_arith[j];
            end
        end
    end

    assign step    = (rem > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : rem[2:0];
    assign rem_nxt = rem - AMT_W'(step);

    shifter u_shifter (
        .din   (acc),
        .by    (step),
        .lr    (lr),
        .arith (arith),
        .dout  (shift_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by reset so every output reads 0 while reset is held.
                if (found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                end
                if (found) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (rem_nxt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid[g] = 1'b1;
                resp_data     = acc;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            g     <= '0;
            acc   <= '0;
            rem   <= '0;
            lr    <= 1'b0;
            arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        acc   <= sel_data;
                        rem   <= sel_amt;
                        lr    <= sel_lr;
                        arith <= sel_arith;
                        g     <= grant_idx;
                        ptr   <= PTR_W'((int'(grant_idx) + 1) % NREQ);
                    end
                end
                SHIFT: begin
                    acc <= shift_out;
                    rem <= rem_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
